// File: rtl/circular_pointer_reader_pkg.sv
// -----------------------------------------------------------------------------
// circular_pointer_reader_pkg
// Shared defaults for the circular-pointer FIFO reader and its surroundings:
// data width / FIFO depth defaults, the skid-buffer depth, the reader FSM
// state encoding and the next-state helper used by the reader FSM.
// -----------------------------------------------------------------------------
package circular_pointer_reader_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // State after the edge, derived from post-edge occupancy: a full buffer that
  // the consumer is not draining is a stall, any content is running.
  function automatic state_t next_state(input logic [1:0] occ_next,
                                        input logic       out_ready);
    state_t st;
    if ((occ_next == 2'd2) && !out_ready) begin
      st = ST_STALL;
    end else if (occ_next != 2'd0) begin
      st = ST_RUN;
    end else begin
      st = ST_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/circular_pointer_reader_skid_buf.sv
// -----------------------------------------------------------------------------
// reader_skid_buf
// Two-entry circular output buffer sitting between the upstream FIFO and the
// downstream consumer. One-bit write/read pointers plus a 2-bit occupancy.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_flush       synchronous clear of occupancy and pointers
//   i_push        write i_wr_data into entry wr_ptr
//   i_pop         consumer accepted the head entry
//   o_rd_data     head entry (entry rd_ptr)
//   o_occ         current occupancy (0..2)
//   o_occ_next    occupancy after the coming edge
// -----------------------------------------------------------------------------
module reader_skid_buf
  import circular_pointer_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [1:0]       o_occ,
  output logic [1:0]       o_occ_next
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_next;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_occ_next = r_occ;
    if (i_flush) begin
      w_occ_next = 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   w_occ_next = r_occ + 2'd1;
        2'b01:   w_occ_next = r_occ - 2'd1;
        default: w_occ_next = r_occ;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (i_flush) begin
      r_occ    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_occ <= w_occ_next;
      if (i_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Data storage; contents are meaningless while occupancy says empty, so no reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_occ      = r_occ;
  assign o_occ_next = w_occ_next;

endmodule

// File: rtl/circular_pointer_reader.sv
// -----------------------------------------------------------------------------
// circular_pointer_reader
// Drains an upstream circular-pointer FIFO into a valid/ready stream through a
// 2-entry skid buffer. The pop strobe depends only on registered occupancy, so
// there is no combinational path from out_ready to fifo_pop.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   en                    drain enable (buffered words still delivered when 0)
//   flush                 synchronous discard of buffered words and rd_count
//   fifo_empty/fifo_data  upstream FIFO status and head word
//   fifo_pop              combinational pop strobe to the upstream FIFO
//   out_valid/out_ready/out_data  downstream stream
//   rd_count              words accepted since reset/flush, wrapping
// -----------------------------------------------------------------------------
module circular_pointer_reader
  import circular_pointer_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] rd_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       w_occ;
  logic [1:0]       w_occ_next;
  logic             w_pop;
  logic             w_accept;
  logic [CNT_W-1:0] r_rd_count;
  state_t           r_state;

  // rst gates the strobe so it is low for the whole reset, not just after an edge.
  assign w_pop     = rst & en & ~flush & ~fifo_empty & (w_occ != 2'(BUF_DEPTH));
  assign out_valid = (w_occ != 2'd0);
  // An accept in a flush cycle is discarded along with the buffer.
  assign w_accept  = out_valid & out_ready & ~flush;
  assign fifo_pop  = w_pop;
  assign rd_count  = r_rd_count;

  reader_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid_buf (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_push     (w_pop),
    .i_wr_data  (fifo_data),
    .i_pop      (w_accept),
    .o_rd_data  (out_data),
    .o_occ      (w_occ),
    .o_occ_next (w_occ_next)
  );

  // Reader FSM: tracks idle / running / stalled-on-full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= next_state(w_occ_next, out_ready);
        ST_RUN:   r_state <= next_state(w_occ_next, out_ready);
        ST_STALL: r_state <= next_state(w_occ_next, out_ready);
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Accepted-word counter, wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count <= {CNT_W{1'b0}};
    end else if (flush) begin
      r_rd_count <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_rd_count <= r_rd_count + CNT_W'(1);
    end else begin
      r_rd_count <= r_rd_count;
    end
  end

endmodule

// File: tb/tb_circular_pointer_reader.sv
// -----------------------------------------------------------------------------
// tb_circular_pointer_reader
// Scoreboard bench: a queue models the upstream FIFO, a second queue holds the
// words the reader has popped and must deliver in order.
// -----------------------------------------------------------------------------
module tb_circular_pointer_reader;
  import circular_pointer_reader_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = 8'h00;
  logic          out_ready = 1'b0;
  logic          fifo_pop;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] rd_count;

  logic [W-1:0]  fq[$];   // upstream FIFO contents
  logic [W-1:0]  sb[$];   // words held by the reader, oldest first
  int            exp_cnt = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  circular_pointer_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: present FIFO head, check outputs against the model,
  // then advance the model across the rising edge. Entered and left at negedge.
  task automatic step();
    logic exp_pop;
    logic exp_acc;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    exp_pop = rst && en && !flush && (fq.size() != 0) && (sb.size() != 2);
    exp_acc = (sb.size() != 0) && out_ready && !flush;
    check_eq("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      check_eq("out_data", {24'd0, out_data}, {24'd0, sb[0]});
    end
    check_eq("rd_count", {29'd0, rd_count}, exp_cnt % (1 << CW));
    @(posedge clk);
    if (flush) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (exp_acc) begin
        void'(sb.pop_front());
        exp_cnt++;
      end
      if (exp_pop) begin
        sb.push_back(fq.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with data waiting upstream: nothing may pop.
    fq = '{8'h11, 8'h22};
    en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    repeat (2) step();
    rst = 1'b1;
    // Pop in cycle 1, 0x11 in cycle 2, 0x22 in cycle 3.
    repeat (4) step();
    check_eq("rd_count_after_reset", {29'd0, rd_count}, 32'd2);

    // Backpressure: two pops fill the buffer, then stall.
    out_ready = 1'b0;
    fq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    repeat (3) step();
    check_eq("state_stall", {30'd0, dut.r_state}, {30'd0, ST_STALL});
    out_ready = 1'b1;
    repeat (6) step();

    // Enable low with one buffered word: it drains, nothing more pops.
    fq = '{8'h5A};
    out_ready = 1'b0;
    step();
    en = 1'b0;
    fq.push_back(8'h33);
    fq.push_back(8'h44);
    out_ready = 1'b1;
    repeat (3) step();
    en = 1'b1;
    repeat (4) step();

    // Flush with a full buffer and a simultaneous accept.
    out_ready = 1'b0;
    fq = '{8'h01, 8'h02, 8'h03};
    repeat (2) step();
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    step();
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_count", {29'd0, rd_count}, 32'd0);
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    // Mid-burst asynchronous reset between edges.
    out_ready = 1'b0;
    fq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    repeat (2) step();
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_pop", {31'd0, fifo_pop}, 32'd0);
    check_eq("async_rst_count", {29'd0, rd_count}, 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();

    // Random traffic, including counter wrap and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      if ((($urandom % 2) != 0) && (fq.size() < D)) begin
        fq.push_back(8'($urandom));
      end
      step();
    end
    flush = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();
    check_eq("drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
